// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 64-bit memory between
// instruction fetch and load/store, data first with a fetch starvation bound.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    NO_STORE    = 2'd0,
    STORE_BYTE  = 2'd1,
    STORE_WORD  = 2'd2,
    STORE_DWORD = 2'd3
  } mem_store_type_t;
endpackage

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inst_req,
  input  logic [63:0]     inst_addr,
  output logic            inst_ready,
  output logic [31:0]     inst_rdata,
  input  logic            data_req,
  input  logic [63:0]     data_addr,
  input  logic [63:0]     data_wdata,
  input  mem_store_type_t data_store_type,
  output logic            data_ready,
  output logic [63:0]     data_rdata,
  output logic [63:0]     mem_addr,
  output logic [63:0]     mem_wdata,
  output mem_store_type_t mem_store_type,
  input  logic [63:0]     mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  state_t          r_state;
  logic            r_owner_d;
  logic [3:0]      r_cnt;
  logic [3:0]      r_streak;
  logic            r_inst_ready;
  logic            r_data_ready;
  logic            r_busy;
  logic [31:0]     r_inst_rdata;
  logic [63:0]     r_data_rdata;
  logic [63:0]     r_mem_addr;
  logic [63:0]     r_mem_wdata;
  mem_store_type_t r_mem_st;

  logic w_starved;
  logic w_grant_d;
  logic w_grant_i;

  assign w_starved = inst_req & (r_streak == LIMIT);
  assign w_grant_d = data_req & ~w_starved;
  assign w_grant_i = inst_req & ~w_grant_d;

  assign inst_ready     = r_inst_ready;
  assign inst_rdata     = r_inst_rdata;
  assign data_ready     = r_data_ready;
  assign data_rdata     = r_data_rdata;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_store_type = r_mem_st;
  assign busy           = r_busy;

  // Access sequencer: grant in IDLE, hold port in BUSY, pulse ready in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_owner_d    <= 1'b0;
      r_cnt        <= '0;
      r_streak     <= '0;
      r_inst_ready <= 1'b0;
      r_data_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_st     <= NO_STORE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_mem_addr  <= data_addr;
            r_mem_wdata <= data_wdata;
            r_mem_st    <= data_store_type;
            r_owner_d   <= 1'b1;
            r_streak    <= inst_req ? r_streak + 4'd1 : 4'd0;
          end else if (w_grant_i) begin
            r_mem_addr  <= inst_addr;
            r_mem_wdata <= '0;
            r_mem_st    <= NO_STORE;
            r_owner_d   <= 1'b0;
            r_streak    <= '0;
          end
          if (w_grant_d | w_grant_i) begin
            r_cnt   <= LAT_M1;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_mem_st <= NO_STORE;
            if (r_owner_d) begin
              r_data_rdata <= mem_rdata;
              r_data_ready <= 1'b1;
            end else begin
              r_inst_rdata <= r_mem_addr[2] ? mem_rdata[31:0]
                                            : mem_rdata[63:32];
              r_inst_ready <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_inst_ready <= 1'b0;
          r_data_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (latency 1 / 3) driven by
// directed and random requests against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic [7:0] LATS = {4'd3, 4'd1};
  localparam logic [7:0] STVS = {4'd4, 4'd2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n      [2];
  logic            inst_req   [2];
  logic [63:0]     inst_addr  [2];
  logic            inst_ready [2];
  logic [31:0]     inst_rdata [2];
  logic            data_req   [2];
  logic [63:0]     data_addr  [2];
  logic [63:0]     data_wdata [2];
  mem_store_type_t data_st    [2];
  logic            data_ready [2];
  logic [63:0]     data_rdata [2];
  logic [63:0]     mem_addr   [2];
  logic [63:0]     mem_wdata  [2];
  mem_store_type_t mem_st     [2];
  logic [63:0]     mem_rdata  [2];
  logic            busy       [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .MEM_LATENCY (int'(LATS[g*4+:4])),
      .STARVE_LIMIT(int'(STVS[g*4+:4]))
    ) u_dut (
      .clk            (clk),
      .reset_n        (rst_n[g]),
      .inst_req       (inst_req[g]),
      .inst_addr      (inst_addr[g]),
      .inst_ready     (inst_ready[g]),
      .inst_rdata     (inst_rdata[g]),
      .data_req       (data_req[g]),
      .data_addr      (data_addr[g]),
      .data_wdata     (data_wdata[g]),
      .data_store_type(data_st[g]),
      .data_ready     (data_ready[g]),
      .data_rdata     (data_rdata[g]),
      .mem_addr       (mem_addr[g]),
      .mem_wdata      (mem_wdata[g]),
      .mem_store_type (mem_st[g]),
      .mem_rdata      (mem_rdata[g]),
      .busy           (busy[g])
    );
  end

  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] a,
                                        logic [63:0] wd, mem_store_type_t t);
    logic [63:0] r;
    int lo;
    r = old;
    case (t)
      STORE_BYTE: begin
        lo = 56 - 8 * int'(a[2:0]);
        r[lo+:8] = wd[7:0];
      end
      STORE_WORD: begin
        lo = a[2] ? 0 : 32;
        r[lo+:32] = wd[31:0];
      end
      STORE_DWORD: r = wd;
      default: ;
    endcase
    return r;
  endfunction

  // Memory array behind each arbiter
  logic [63:0] env_mem [2][16];
  logic        mem_clr;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_clr) begin
        for (int i = 0; i < 16; i++) env_mem[k][i] <= '0;
      end else if (mem_st[k] != NO_STORE) begin
        env_mem[k][mem_addr[k][6:3]] <=
          merge(env_mem[k][mem_addr[k][6:3]], mem_addr[k],
                mem_wdata[k], mem_st[k]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) mem_rdata[k] = env_mem[k][mem_addr[k][6:3]];
  end

  // Reference model state
  logic [63:0] gold   [2][16];
  int          streak_m [2];
  logic [31:0] exp_ir [2];
  logic [63:0] exp_dr [2];
  bit          dr_ok  [2];
  int          checks;
  int          fails;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_reset(input int k);
    streak_m[k] = 0;
    exp_ir[k]   = '0;
    exp_dr[k]   = '0;
    dr_ok[k]    = 1'b1;
  endtask

  task automatic rst_chk(input int k);
    check("rst_busy", busy[k], 0);
    check("rst_iready", inst_ready[k], 0);
    check("rst_dready", data_ready[k], 0);
    check("rst_irdata", inst_rdata[k], 0);
    check("rst_drdata", data_rdata[k], 0);
    check("rst_maddr", mem_addr[k], 0);
    check("rst_mwdata", mem_wdata[k], 0);
    check("rst_mst", mem_st[k], NO_STORE);
  endtask

  // One arbitration round starting at the negedge of an IDLE cycle.
  // who: 0 = nothing granted, 1 = fetch, 2 = data.
  task automatic do_round(input int k, output int who);
    int lat;
    int stv;
    logic [63:0] ea;
    logic [63:0] ew;
    logic [63:0] w;
    mem_store_type_t et;
    lat = int'(LATS[k*4+:4]);
    stv = int'(STVS[k*4+:4]);
    check("idle_busy", busy[k], 0);
    check("idle_iready", inst_ready[k], 0);
    check("idle_dready", data_ready[k], 0);
    check("idle_mst", mem_st[k], NO_STORE);
    who = 0;
    if (inst_req[k] && data_req[k]) begin
      if (streak_m[k] >= stv) begin
        who = 1;
        streak_m[k] = 0;
      end else begin
        who = 2;
        streak_m[k]++;
      end
    end else if (data_req[k]) begin
      who = 2;
      streak_m[k] = 0;
    end else if (inst_req[k]) begin
      who = 1;
      streak_m[k] = 0;
    end
    if (who == 0) begin
      @(posedge clk);
      @(negedge clk);
      return;
    end
    if (who == 1) begin
      ea = inst_addr[k];
      ew = '0;
      et = NO_STORE;
      w  = gold[k][ea[6:3]];
      exp_ir[k] = ea[2] ? w[31:0] : w[63:32];
    end else begin
      ea = data_addr[k];
      ew = data_wdata[k];
      et = data_st[k];
      if (et == NO_STORE) begin
        exp_dr[k] = gold[k][ea[6:3]];
        dr_ok[k]  = 1'b1;
      end else begin
        gold[k][ea[6:3]] = merge(gold[k][ea[6:3]], ea, ew, et);
        dr_ok[k] = 1'b0;
      end
    end
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check("busy_busy", busy[k], 1);
      check("busy_iready", inst_ready[k], 0);
      check("busy_dready", data_ready[k], 0);
      check("busy_maddr", mem_addr[k], ea);
      check("busy_mwdata", mem_wdata[k], ew);
      check("busy_mst", mem_st[k], et);
      if (c == 1) begin
        if (who == 1) begin
          inst_addr[k] = rnd64();
        end else begin
          data_addr[k]  = rnd64();
          data_wdata[k] = rnd64();
          data_st[k]    = mem_store_type_t'($urandom_range(3, 0));
        end
      end
    end
    @(negedge clk);
    check("resp_busy", busy[k], 1);
    check("resp_iready", inst_ready[k], (who == 1));
    check("resp_dready", data_ready[k], (who == 2));
    check("resp_mst", mem_st[k], NO_STORE);
    check("resp_irdata", inst_rdata[k], exp_ir[k]);
    if (dr_ok[k]) check("resp_drdata", data_rdata[k], exp_dr[k]);
    if (who == 1) inst_req[k] = 1'b0;
    else data_req[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic data_op(input int k, input logic [63:0] a,
                         input logic [63:0] wd, input mem_store_type_t t);
    int who;
    data_req[k]   = 1'b1;
    data_addr[k]  = a;
    data_wdata[k] = wd;
    data_st[k]    = t;
    do_round(k, who);
    check("who_data", who, 2);
  endtask

  task automatic inst_op(input int k, input logic [63:0] a);
    int who;
    inst_req[k]  = 1'b1;
    inst_addr[k] = a;
    do_round(k, who);
    check("who_inst", who, 1);
  endtask

  task automatic raise_rand(input int k, input bit force_req);
    if (!inst_req[k] && (force_req || $urandom_range(1, 0) == 1)) begin
      inst_req[k]  = 1'b1;
      inst_addr[k] = rnd64();
    end
    if (!data_req[k] && (force_req || $urandom_range(1, 0) == 1)) begin
      data_req[k]   = 1'b1;
      data_addr[k]  = rnd64();
      data_wdata[k] = rnd64();
      data_st[k]    = mem_store_type_t'($urandom_range(3, 0));
    end
  endtask

  task automatic rand_rounds(input int k, input int n);
    int who;
    for (int i = 0; i < n; i++) begin
      raise_rand(k, 1'b0);
      do_round(k, who);
    end
    for (int i = 0; i < 3; i++) begin
      if (inst_req[k] || data_req[k]) do_round(k, who);
    end
  endtask

  initial begin
    int who;
    logic [11:0] code;
    checks  = 0;
    fails   = 0;
    mem_clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rst_n[k]      = 1'b0;
      inst_req[k]   = 1'b0;
      inst_addr[k]  = '0;
      data_req[k]   = 1'b0;
      data_addr[k]  = '0;
      data_wdata[k] = '0;
      data_st[k]    = NO_STORE;
      for (int i = 0; i < 16; i++) gold[k][i] = '0;
      model_reset(k);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    for (int k = 0; k < 2; k++) rst_chk(k);
    for (int k = 0; k < 2; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) rst_chk(k);

    // Latency 1, starve limit 2
    data_op(0, 64'h10, 64'h11112222_33334444, STORE_DWORD);
    inst_op(0, 64'h14);
    check("fetch14", inst_rdata[0], 32'h33334444);
    inst_op(0, 64'h10);
    check("fetch10", inst_rdata[0], 32'h11112222);
    data_op(0, 64'h40, 64'hDEADBEEF_CAFEF00D, STORE_DWORD);
    data_op(0, 64'h40, 64'h0, NO_STORE);
    check("load40", data_rdata[0], 64'hDEADBEEF_CAFEF00D);
    code = '0;
    for (int i = 0; i < 6; i++) begin
      raise_rand(0, 1'b1);
      do_round(0, who);
      code = {code[9:0], 2'(who)};
    end
    check("starve_seq", code, 12'hA69);
    inst_req[0] = 1'b0;
    data_req[0] = 1'b0;
    rand_rounds(0, 200);

    // Latency 3, starve limit 4
    data_op(1, 64'h88, 64'h55667788_99AABBCC, STORE_DWORD);
    inst_op(1, 64'h8C);
    check("fetch8c", inst_rdata[1], 32'h99AABBCC);
    rand_rounds(1, 200);
    inst_req[1] = 1'b0;
    data_req[1] = 1'b0;

    // Reset in the middle of a timed store, then reissue
    @(negedge clk);
    data_req[1]   = 1'b1;
    data_addr[1]  = 64'h58;
    data_wdata[1] = 64'h01234567_89ABCDEF;
    data_st[1]    = STORE_DWORD;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy[1], 1);
    check("mid_mst", mem_st[1], STORE_DWORD);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check("abort_busy", busy[1], 0);
    check("abort_mst", mem_st[1], NO_STORE);
    check("abort_dready", data_ready[1], 0);
    check("abort_maddr", mem_addr[1], 0);
    model_reset(1);
    @(negedge clk);
    check("abort_noready", data_ready[1], 0);
    rst_n[1] = 1'b1;
    do_round(1, who);
    check("reissue_who", who, 2);
    data_op(1, 64'h58, 64'h0, NO_STORE);
    check("load58", data_rdata[1], 64'h01234567_89ABCDEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
